// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one uart_tx serializer between NUM_REQ
// byte requesters. Each grant sends an optional header byte (HEADER_BASE | grant id)
// followed by the requester's payload byte.
//
// Ports:
//   i_Clock      clock
//   i_Reset      asynchronous active-high reset
//   i_Req_Valid  per-requester byte pending, held until acked
//   i_Req_Data   requester k byte at [8k+7:8k], stable while valid
//   o_Req_Ack    one-cycle pulse when requester k's byte is captured
//   o_Tx_DV      data valid to uart_tx
//   o_Tx_Byte    byte to uart_tx, holds its last value outside SEND states
//   i_Tx_Active  uart_tx busy
//   i_Tx_Done    uart_tx byte-complete pulse
//   o_Grant_Id   index of the current/last owner
//   o_Busy       high in every state except IDLE
//   o_Error      one-cycle pulse when a byte times out waiting for done
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned HEADER_EN    = 1,
    parameter logic [7:0]  HEADER_BASE  = 8'hA0,
    parameter int unsigned TIMEOUT_CLKS = 12000
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic [NUM_REQ-1:0]   i_Req_Valid,
    input  logic [8*NUM_REQ-1:0] i_Req_Data,
    output logic [NUM_REQ-1:0]   o_Req_Ack,
    output logic                 o_Tx_DV,
    output logic [7:0]           o_Tx_Byte,
    input  logic                 i_Tx_Active,
    input  logic                 i_Tx_Done,
    output logic [2:0]           o_Grant_Id,
    output logic                 o_Busy,
    output logic                 o_Error
);

    typedef enum logic [2:0] {
        StIdle,
        StSendHdr,
        StWaitHdr,
        StSendData,
        StWaitData
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         last_q, last_d;
    logic [2:0]         grant_q, grant_d;
    logic [7:0]         payload_q, payload_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic               tx_dv_q, tx_dv_d;
    logic               busy_q, busy_d;
    logic               error_q, error_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [31:0]        cnt_q, cnt_d;

    logic [7:0]  valid_pad;
    logic [63:0] data_pad;
    logic        found;
    logic [2:0]  winner;
    logic [3:0]  idx;
    logic [7:0]  win_data;
    logic        timeout_hit;

    // Pad to the 8-requester maximum so a 3-bit index is always in range.
    assign valid_pad = 8'(i_Req_Valid);
    assign data_pad  = 64'(i_Req_Data);
    assign win_data  = data_pad[{winner, 3'b000} +: 8];

    // Round-robin search starting at last_grant+1, wrapping modulo NUM_REQ.
    always_comb begin
        found  = 1'b0;
        winner = 3'd0;
        idx    = 4'd0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = {1'b0, last_q} + 4'(i);
            if (idx >= 4'(NUM_REQ)) begin
                idx = idx - 4'(NUM_REQ);
            end
            if (!found && valid_pad[idx[2:0]]) begin
                found  = 1'b1;
                winner = idx[2:0];
            end
        end
    end

    // Fires on the WAIT edge at which the count would reach TIMEOUT_CLKS.
    assign timeout_hit = (TIMEOUT_CLKS != 0) && ((cnt_q + 32'd1) == 32'(TIMEOUT_CLKS));

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_q;
        payload_d = payload_q;
        tx_byte_d = tx_byte_q;
        tx_dv_d   = 1'b0;
        ack_d     = '0;
        error_d   = 1'b0;
        cnt_d     = cnt_q;
        unique case (state_q)
            StIdle: begin
                // Waiting for done=0 as well keeps DV out of the serializer's cleanup cycle
                // after a reset that interrupted a byte.
                if (found && !i_Tx_Active && !i_Tx_Done) begin
                    grant_d   = winner;
                    payload_d = win_data;
                    tx_dv_d   = 1'b1;
                    ack_d     = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
                    if (HEADER_EN != 0) begin
                        state_d   = StSendHdr;
                        tx_byte_d = HEADER_BASE | {5'b00000, winner};
                    end else begin
                        state_d   = StSendData;
                        tx_byte_d = win_data;
                    end
                end
            end
            StSendHdr: begin
                state_d = StWaitHdr;
                cnt_d   = '0;
            end
            StSendData: begin
                state_d = StWaitData;
                cnt_d   = '0;
            end
            StWaitHdr: begin
                cnt_d = cnt_q + 32'd1;
                if (i_Tx_Done) begin
                    state_d   = StSendData;
                    tx_dv_d   = 1'b1;
                    tx_byte_d = payload_q;
                end else if (timeout_hit) begin
                    error_d = 1'b1;
                    last_d  = grant_q;
                    state_d = StIdle;
                end
            end
            StWaitData: begin
                cnt_d = cnt_q + 32'd1;
                if (i_Tx_Done) begin
                    last_d  = grant_q;
                    state_d = StIdle;
                end else if (timeout_hit) begin
                    error_d = 1'b1;
                    last_d  = grant_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= StIdle;
            last_q    <= 3'(NUM_REQ - 1);
            grant_q   <= 3'd0;
            payload_q <= 8'd0;
            tx_byte_q <= 8'd0;
            tx_dv_q   <= 1'b0;
            busy_q    <= 1'b0;
            error_q   <= 1'b0;
            ack_q     <= '0;
            cnt_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            payload_q <= payload_d;
            tx_byte_q <= tx_byte_d;
            tx_dv_q   <= tx_dv_d;
            busy_q    <= busy_d;
            error_q   <= error_d;
            ack_q     <= ack_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_Req_Ack  = ack_q;
    assign o_Tx_DV    = tx_dv_q;
    assign o_Tx_Byte  = tx_byte_q;
    assign o_Grant_Id = grant_q;
    assign o_Busy     = busy_q;
    assign o_Error    = error_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter. Instance A: header on, timeout 20, uart model with done.
// Instance B: header off, timeout 100, uart model that goes active but never signals done.
// Expected DV transactions are queued by the stimulus and checked by a negedge monitor.
module tb_uart_tx_arbiter;

    typedef struct packed {
        logic       inst;
        logic [7:0] b;
        logic [2:0] id;
        logic [3:0] ack;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst      [2];
    logic [3:0]  vld      [2];
    logic [31:0] dat      [2];
    logic [3:0]  ack      [2];
    logic        dv       [2];
    logic [7:0]  txb      [2];
    logic [2:0]  gid      [2];
    logic        busy     [2];
    logic        err      [2];
    logic        act_w    [2];
    logic        m_act    [2] = '{1'b0, 1'b0};
    logic        m_done   [2] = '{1'b0, 1'b0};
    int          m_cnt    [2] = '{0, 0};
    int          m_lat    [2] = '{10, 150};
    bit          m_done_en[2] = '{1'b1, 1'b0};
    logic        hold_act = 1'b0;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   errs [2] = '{0, 0};
    exp_t sb [$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign act_w[0] = m_act[0] | hold_act;
    assign act_w[1] = m_act[1];

    uart_tx_arbiter #(
        .NUM_REQ(4), .HEADER_EN(1), .HEADER_BASE(8'hA0), .TIMEOUT_CLKS(20)
    ) u_dut_a (
        .i_Clock(clk), .i_Reset(rst[0]), .i_Req_Valid(vld[0]), .i_Req_Data(dat[0]),
        .o_Req_Ack(ack[0]), .o_Tx_DV(dv[0]), .o_Tx_Byte(txb[0]), .i_Tx_Active(act_w[0]),
        .i_Tx_Done(m_done[0]), .o_Grant_Id(gid[0]), .o_Busy(busy[0]), .o_Error(err[0])
    );

    uart_tx_arbiter #(
        .NUM_REQ(4), .HEADER_EN(0), .HEADER_BASE(8'hA0), .TIMEOUT_CLKS(100)
    ) u_dut_b (
        .i_Clock(clk), .i_Reset(rst[1]), .i_Req_Valid(vld[1]), .i_Req_Data(dat[1]),
        .o_Req_Ack(ack[1]), .o_Tx_DV(dv[1]), .o_Tx_Byte(txb[1]), .i_Tx_Active(act_w[1]),
        .i_Tx_Done(m_done[1]), .o_Grant_Id(gid[1]), .o_Busy(busy[1]), .o_Error(err[1])
    );

    // uart_tx model: accepts DV when idle; done is sampled by the arbiter m_lat edges later.
    always @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (m_act[n]) begin
                if (m_done[n] || (!m_done_en[n] && m_cnt[n] >= m_lat[n])) begin
                    m_act[n]  <= 1'b0;
                    m_done[n] <= 1'b0;
                end else begin
                    m_cnt[n]  <= m_cnt[n] + 1;
                    m_done[n] <= m_done_en[n] && (m_cnt[n] == m_lat[n] - 1);
                end
            end else if (dv[n]) begin
                m_act[n]  <= 1'b1;
                m_cnt[n]  <= 1;
                m_done[n] <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (dv[n]) begin
                if (sb.size() == 0 || sb[0].inst != n[0]) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_dv inst=%0d: got byte %02h id %0d, expected none",
                             n, txb[n], gid[n]);
                end else begin
                    mon_e = sb.pop_front();
                    chk("tx_byte", 32'(txb[n]), 32'(mon_e.b));
                    chk("grant_id", 32'(gid[n]), 32'(mon_e.id));
                    chk("req_ack", 32'(ack[n]), 32'(mon_e.ack));
                end
            end else if (ack[n] != 4'd0) begin
                total++;
                bad++;
                $display("FAIL stray_ack inst=%0d: got %b, expected 0000", n, ack[n]);
            end
            if (err[n]) errs[n]++;
        end
    end

    task automatic push(input int n, input logic [7:0] b, input logic [2:0] id,
                        input logic [3:0] a);
        exp_t e;
        e.inst = n[0];
        e.b    = b;
        e.id   = id;
        e.ack  = a;
        sb.push_back(e);
    endtask

    task automatic push_frame(input int n, input logic [2:0] id, input bit hdr,
                              input logic [7:0] data);
        if (hdr) begin
            push(n, 8'hA0 | {5'd0, id}, id, 4'b0001 << id);
            push(n, data, id, 4'b0000);
        end else begin
            push(n, data, id, 4'b0001 << id);
        end
    endtask

    // Event selectors: 0 dv, 1 error, 2 done, 3 any ack, 4 idle with scoreboard drained.
    function automatic bit sig(input int n, input int w);
        case (w)
            0:       return dv[n];
            1:       return err[n];
            2:       return m_done[n];
            3:       return ack[n] != 4'd0;
            default: return !busy[n] && sb.size() == 0;
        endcase
    endfunction

    task automatic wait_sig(input int n, input int w, output int c);
        c = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (sig(n, w)) begin
                c = cyc;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL wait_event%0d inst=%0d: got no event in 3000 cycles, expected one", w, n);
    endtask

    task automatic chk_reset(input int n);
        chk("rst_dv", 32'(dv[n]), 0);
        chk("rst_byte", 32'(txb[n]), 0);
        chk("rst_ack", 32'(ack[n]), 0);
        chk("rst_busy", 32'(busy[n]), 0);
        chk("rst_error", 32'(err[n]), 0);
        chk("rst_grant", 32'(gid[n]), 0);
    endtask

    initial begin
        int c0;
        int ce;
        int c;
        rst = '{1'b1, 1'b1};
        vld = '{4'd0, 4'd0};
        dat = '{32'd0, 32'd0};
        repeat (3) @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        rst = '{1'b0, 1'b0};
        @(negedge clk);

        // Single request with header.
        dat[0] = 32'h0000_0055;
        vld[0] = 4'b0001;
        push_frame(0, 3'd0, 1'b1, 8'h55);
        wait_sig(0, 3, c);
        vld[0] = 4'b0000;
        wait_sig(0, 2, c);
        chk("t1_busy_mid", 32'(busy[0]), 1);
        wait_sig(0, 2, c);
        @(negedge clk);
        chk("t1_busy_fall", 32'(busy[0]), 0);

        // All four valid continuously from a fresh reset.
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        dat[0] = 32'h4433_2211;
        vld[0] = 4'b1111;
        push_frame(0, 3'd0, 1'b1, 8'h11);
        push_frame(0, 3'd1, 1'b1, 8'h22);
        push_frame(0, 3'd2, 1'b1, 8'h33);
        push_frame(0, 3'd3, 1'b1, 8'h44);
        push_frame(0, 3'd0, 1'b1, 8'h11);
        for (int k = 0; k < 5; k++) wait_sig(0, 3, c);
        vld[0] = 4'b0000;
        wait_sig(0, 4, c);

        // req2 withdraws before arbitration; req3 wins after req1.
        dat[0] = 32'hD4C3_B2A1;
        vld[0] = 4'b0010;
        push_frame(0, 3'd1, 1'b1, 8'hB2);
        push_frame(0, 3'd3, 1'b1, 8'hD4);
        wait_sig(0, 3, c);
        vld[0] = 4'b1100;
        repeat (5) @(negedge clk);
        vld[0] = 4'b1000;
        wait_sig(0, 3, c);
        vld[0] = 4'b0000;
        wait_sig(0, 4, c);
        chk("t3_grant_id", 32'(gid[0]), 3);

        // Timeout on instance B, then rotation to the next requester.
        dat[1] = 32'h0000_3CC3;
        vld[1] = 4'b0011;
        push_frame(1, 3'd0, 1'b0, 8'hC3);
        push_frame(1, 3'd1, 1'b0, 8'h3C);
        wait_sig(1, 0, c0);
        vld[1] = 4'b0010;
        wait_sig(1, 1, ce);
        chk("b_timeout_lat0", 32'(ce - c0), 101);
        chk("b_idle_after_err", 32'(busy[1]), 0);
        wait_sig(1, 0, c0);
        vld[1] = 4'b0000;
        wait_sig(1, 1, ce);
        chk("b_timeout_lat1", 32'(ce - c0), 101);

        // Reset in the middle of a payload byte while the serializer stays active.
        dat[0] = 32'h0088_6644;
        vld[0] = 4'b0010;
        push_frame(0, 3'd1, 1'b1, 8'h66);
        wait_sig(0, 3, c);
        vld[0] = 4'b0000;
        wait_sig(0, 0, c);
        repeat (3) @(negedge clk);
        rst[0]   = 1'b1;
        hold_act = 1'b1;
        vld[0]   = 4'b0101;
        #1;
        chk_reset(0);
        @(negedge clk);
        rst[0] = 1'b0;
        repeat (500) @(negedge clk);
        hold_act = 1'b0;
        push_frame(0, 3'd0, 1'b1, 8'h44);
        push_frame(0, 3'd2, 1'b1, 8'h88);
        wait_sig(0, 3, c);
        vld[0] = 4'b0100;
        wait_sig(0, 3, c);
        vld[0] = 4'b0000;
        wait_sig(0, 4, c);

        // Done arrives on the same edge the timeout would fire.
        m_lat[0] = 20;
        dat[0]   = 32'h9900_0000;
        vld[0]   = 4'b1000;
        push_frame(0, 3'd3, 1'b1, 8'h99);
        wait_sig(0, 3, c);
        vld[0] = 4'b0000;
        wait_sig(0, 4, c);
        chk("a_error_count", 32'(errs[0]), 0);
        chk("b_error_count", 32'(errs[1]), 2);
        chk("sb_empty", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one `uart_tx` serializer between `NUM_REQ` byte requesters. Each grant sends a two-byte frame (optional channel header, then payload) by driving the transmitter's data-valid/byte inputs and sequencing on its done/active outputs. It sits between the FPGA's message sources and the single `uart_tx` instance driving the host serial line.

## Interface

- `NUM_REQ`, 4: number of requesters, legal range 2..8.
- `HEADER_EN`, 1: 1 = prefix each payload with a header byte; 0 = payload only.
- `HEADER_BASE`, 8'hA0: header byte is `HEADER_BASE | grant_id`, with `grant_id` in the low 3 bits.
- `TIMEOUT_CLKS`, 12000: maximum cycles to wait for `i_Tx_Done` per byte; 0 disables the timeout.

Ports:

- `i_Clock`  in  1  sole clock.
- `i_Reset`  in  1  asynchronous, active-high reset.
- `i_Req_Valid`  in  NUM_REQ  requester k has a byte pending; held until acked.
- `i_Req_Data`  in  8*NUM_REQ  byte of requester k at [8k+7:8k]; stable while valid.
- `o_Req_Ack`  out  NUM_REQ  one-cycle pulse: requester k's byte captured.
- `o_Tx_DV`  out  1  to `uart_tx` `i_Tx_DV`.
- `o_Tx_Byte`  out  8  to `uart_tx` `i_Tx_Byte`.
- `i_Tx_Active`  in  1  from `uart_tx` `o_Tx_Active`.
- `i_Tx_Done`  in  1  from `uart_tx` `o_Tx_Done`.
- `o_Grant_Id`  out  3  index of the current/last owner.
- `o_Busy`  out  1  high in every state except IDLE.
- `o_Error`  out  1  one-cycle pulse on timeout.

## Operation

- States: IDLE, SEND_HDR, WAIT_HDR, SEND_DATA, WAIT_DATA.
- IDLE: grant only when `|i_Req_Valid` is high, `i_Tx_Active`=0 and `i_Tx_Done`=0.
  - Winner: first valid index searching from `last_grant+1` mod NUM_REQ upward with wrap.
  - At the grant edge: capture the winner's byte, set `o_Grant_Id`, and go to SEND_HDR (HEADER_EN=1) or SEND_DATA (HEADER_EN=0).
- SEND_x: exactly one cycle. `o_Tx_DV`=1 and `o_Tx_Byte` holds the header or the captured payload. Next state is the matching WAIT_x.
- WAIT_HDR: on `i_Tx_Done`=1, go to SEND_DATA.
- WAIT_DATA: on `i_Tx_Done`=1, set `last_grant`=`o_Grant_Id` and go to IDLE.
- Timeout counter (32-bit):
  - Cleared on entry to each WAIT_x; increments every WAIT cycle.
  - On reaching TIMEOUT_CLKS (when nonzero): pulse `o_Error`, set `last_grant`=`o_Grant_Id`, go to IDLE. The frame is abandoned and not retried.
- A requester that drops valid before being granted is skipped; no ack is issued.
- Valid held high after an ack is a new request, eligible only at the next IDLE arbitration.
- `o_Tx_Byte` holds its last value outside SEND states. `o_Tx_DV`=0 outside SEND states.

## Timing

- All outputs are registered. Reset values:
  - `o_Tx_DV`=0, `o_Tx_Byte`=0, `o_Req_Ack`=0, `o_Busy`=0, `o_Error`=0, `o_Grant_Id`=0.
  - State=IDLE, `last_grant`=NUM_REQ-1, so requester 0 has first priority.
- Grant edge E: in the cycle after E, `o_Req_Ack[w]`=1 and `o_Tx_DV`=1, each for exactly one cycle. Latency from valid sampled to DV is 1 cycle.
- The `uart_tx` instance accepts DV at edge E+1. From that edge the arbiter is in a WAIT state.
- `i_Tx_Done` seen at edge D: the next SEND (or IDLE) state starts after D. This coincides with `uart_tx` returning to its idle state, so DV is never lost in its cleanup cycle.
- The next arbitration is possible at edge D+1. Minimum idle gap between frames is 1 cycle.
- `i_Tx_Done` is ignored outside WAIT states. Done and timeout on the same edge: done wins, `o_Error` stays 0.
- Reset mid-frame: the arbiter returns to IDLE immediately. The serializer, which has no reset, finishes its byte. The IDLE grant condition blocks a new grant until `i_Tx_Active`=0 and `i_Tx_Done`=0.

## Test plan

- Reset, then req0 valid with data 8'h55, HEADER_EN=1: `o_Tx_Byte` sequence A0 then 55; `o_Req_Ack`=4'b0001 pulses once; after the second done `o_Busy` falls.
- All four valid continuously, with data 11/22/33/44: the grant order is 0,1,2,3,0 and the payload stream is 11,22,33,44,11, with no repeated owner while others wait.
- req2 asserts valid, drops it before IDLE, and req3 is valid: only `o_Req_Ack[3]` pulses; `o_Grant_Id`=3 and the header is A3.
- HEADER_EN=0 and TIMEOUT_CLKS=100, with the uart model never returning done: one DV with the payload; `o_Error` pulses exactly 100 cycles after entering WAIT_DATA; then IDLE, and the next grant goes to the following index.
- `i_Reset` asserted mid-payload while the uart model keeps `i_Tx_Active`=1 for 500 more cycles: outputs return to their reset values immediately; no DV is issued until active and done are both 0; the next grant goes to req0.
- Done and timeout coincide (TIMEOUT_CLKS equal to the model's done latency): the frame completes normally and `o_Error` stays 0.
